// File: rtl/mem_access.sv
// mem_access: memory-access stage plus MEM/WB register. Runs loads/stores on a
// req/ack data bus, formats load data, and stalls upstream while a transfer is outstanding.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef REG_W_SRC_WIDTH
`define REG_W_SRC_WIDTH 2
`endif
`ifndef REG_W_DST_WIDTH
`define REG_W_DST_WIDTH 2
`endif

module mem_access #(
    parameter int W = `WORD_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic                        in_mem_read,
    input  logic                        in_mem_write,
    input  logic [1:0]                  in_mem_size,
    input  logic                        in_mem_sign,
    input  logic [W-1:0]                in_alu_result,
    input  logic [W-1:0]                in_store_data,
    input  logic [W-1:0]                in_pc,
    input  logic [`REG_ADDR_W-1:0]      in_rd,
    input  logic [`REG_ADDR_W-1:0]      in_rt,
    input  logic                        in_reg_write_en,
    input  logic [`REG_W_SRC_WIDTH-1:0] in_reg_write_src,
    input  logic [`REG_W_DST_WIDTH-1:0] in_reg_write_dst,
    output logic                        mem_stall,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [W-1:0]                dmem_addr,
    output logic [W-1:0]                dmem_wdata,
    output logic [3:0]                  dmem_be,
    input  logic [W-1:0]                dmem_rdata,
    input  logic                        dmem_ack,
    output logic                        wb_valid,
    output logic                        reg_write_en,
    output logic [W-1:0]                alu_result,
    output logic [W-1:0]                mem_data,
    output logic [W-1:0]                pc,
    output logic [`REG_ADDR_W-1:0]      rd,
    output logic [`REG_ADDR_W-1:0]      rt,
    output logic [`REG_W_SRC_WIDTH-1:0] reg_write_src,
    output logic [`REG_W_DST_WIDTH-1:0] reg_write_dst,
    output logic                        addr_error
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, next_state;

    logic                        is_mem;
    logic                        misaligned;
    logic                        accept_mem;
    logic [3:0]                  be_next;
    logic [W-1:0]                wdata_next;
    logic [7:0]                  byte_v;
    logic [15:0]                 half_v;
    logic [W-1:0]                load_data;

    logic                        cap_read;
    logic                        cap_sign;
    logic [1:0]                  cap_size;
    logic [1:0]                  cap_lane;
    logic [W-1:0]                cap_alu;
    logic [W-1:0]                cap_pc;
    logic [`REG_ADDR_W-1:0]      cap_rd;
    logic [`REG_ADDR_W-1:0]      cap_rt;
    logic                        cap_rwe;
    logic [`REG_W_SRC_WIDTH-1:0] cap_src;
    logic [`REG_W_DST_WIDTH-1:0] cap_dst;

    // Handshake: upstream holds in_valid and its bundle while mem_stall is high; a
    // bundle is consumed on any edge with mem_stall low. dmem_ack is meaningful only
    // while dmem_req is high, which is exactly the BUSY state.
    assign mem_stall = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        is_mem     = in_mem_read | in_mem_write;
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = in_store_data;
        case (in_mem_size)
            2'd0: begin
                be_next    = 4'b0001 << in_alu_result[1:0];
                wdata_next = {4{in_store_data[7:0]}};
            end
            2'd1: begin
                misaligned = in_alu_result[0];
                be_next    = 4'b0011 << in_alu_result[1:0];
                wdata_next = {2{in_store_data[15:0]}};
            end
            default: misaligned = |in_alu_result[1:0];
        endcase
        accept_mem = (state == IDLE) && in_valid && is_mem && !misaligned;

        next_state = state;
        case (state)
            IDLE:    if (accept_mem) next_state = BUSY;
            BUSY:    if (dmem_ack)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Little-endian lane pick on the returned word, then extension.
    always_comb begin
        byte_v = dmem_rdata[7:0];
        case (cap_lane)
            2'd1:    byte_v = dmem_rdata[15:8];
            2'd2:    byte_v = dmem_rdata[23:16];
            2'd3:    byte_v = dmem_rdata[31:24];
            default: byte_v = dmem_rdata[7:0];
        endcase
        half_v = cap_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (cap_size)
            2'd0:    load_data = {{24{cap_sign & byte_v[7]}}, byte_v};
            2'd1:    load_data = {{16{cap_sign & half_v[15]}}, half_v};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            wb_valid      <= 1'b0;
            reg_write_en  <= 1'b0;
            addr_error    <= 1'b0;
            alu_result    <= '0;
            mem_data      <= '0;
            pc            <= '0;
            rd            <= '0;
            rt            <= '0;
            reg_write_src <= '0;
            reg_write_dst <= '0;
            cap_read      <= 1'b0;
            cap_sign      <= 1'b0;
            cap_size      <= '0;
            cap_lane      <= '0;
            cap_alu       <= '0;
            cap_pc        <= '0;
            cap_rd        <= '0;
            cap_rt        <= '0;
            cap_rwe       <= 1'b0;
            cap_src       <= '0;
            cap_dst       <= '0;
        end else begin
            wb_valid     <= 1'b0;
            reg_write_en <= 1'b0;
            addr_error   <= 1'b0;
            if (state == IDLE) begin
                if (accept_mem) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= in_mem_write;
                    dmem_addr  <= {in_alu_result[W-1:2], 2'b00};
                    dmem_be    <= be_next;
                    dmem_wdata <= wdata_next;
                    cap_read   <= in_mem_read;
                    cap_sign   <= in_mem_sign;
                    cap_size   <= in_mem_size;
                    cap_lane   <= in_alu_result[1:0];
                    cap_alu    <= in_alu_result;
                    cap_pc     <= in_pc;
                    cap_rd     <= in_rd;
                    cap_rt     <= in_rt;
                    cap_rwe    <= in_reg_write_en;
                    cap_src    <= in_reg_write_src;
                    cap_dst    <= in_reg_write_dst;
                end else if (in_valid) begin
                    // Non-memory op, or a misaligned access retired with the error flag.
                    wb_valid      <= 1'b1;
                    reg_write_en  <= in_reg_write_en & ~is_mem;
                    addr_error    <= is_mem;
                    alu_result    <= in_alu_result;
                    mem_data      <= '0;
                    pc            <= in_pc;
                    rd            <= in_rd;
                    rt            <= in_rt;
                    reg_write_src <= in_reg_write_src;
                    reg_write_dst <= in_reg_write_dst;
                end
            end else if (dmem_ack) begin
                dmem_req      <= 1'b0;
                wb_valid      <= 1'b1;
                reg_write_en  <= cap_rwe;
                alu_result    <= cap_alu;
                mem_data      <= cap_read ? load_data : '0;
                pc            <= cap_pc;
                rd            <= cap_rd;
                rt            <= cap_rt;
                reg_write_src <= cap_src;
                reg_write_dst <= cap_dst;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: loads, stores, misalignment, ALU pass-through,
// stall/hold behaviour and reset during an outstanding transfer.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef REG_W_SRC_WIDTH
`define REG_W_SRC_WIDTH 2
`endif
`ifndef REG_W_DST_WIDTH
`define REG_W_DST_WIDTH 2
`endif

module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_mem_read, in_mem_write, in_mem_sign, in_reg_write_en;
    logic [1:0]  in_mem_size;
    logic [31:0] in_alu_result, in_store_data, in_pc;
    logic [4:0]  in_rd, in_rt;
    logic [1:0]  in_reg_write_src, in_reg_write_dst;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, reg_write_en, addr_error;
    logic [31:0] alu_result, mem_data, pc;
    logic [4:0]  rd, rt;
    logic [1:0]  reg_write_src, reg_write_dst;

    int tests = 0;
    int fails = 0;
    int sc;

    mem_access #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_size(in_mem_size), .in_mem_sign(in_mem_sign),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_pc(in_pc),
        .in_rd(in_rd), .in_rt(in_rt), .in_reg_write_en(in_reg_write_en),
        .in_reg_write_src(in_reg_write_src), .in_reg_write_dst(in_reg_write_dst),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .reg_write_en(reg_write_en),
        .alu_result(alu_result), .mem_data(mem_data), .pc(pc),
        .rd(rd), .rt(rt), .reg_write_src(reg_write_src), .reg_write_dst(reg_write_dst),
        .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a_read, input logic a_write, input logic [1:0] a_size,
                         input logic a_sign, input logic [31:0] a_addr, input logic [31:0] a_data,
                         input logic [31:0] a_pc, input logic [4:0] a_rd, input logic [4:0] a_rt,
                         input logic a_rwe, input logic [1:0] a_src, input logic [1:0] a_dst);
        in_valid         = 1'b1;
        in_mem_read      = a_read;
        in_mem_write     = a_write;
        in_mem_size      = a_size;
        in_mem_sign      = a_sign;
        in_alu_result    = a_addr;
        in_store_data    = a_data;
        in_pc            = a_pc;
        in_rd            = a_rd;
        in_rt            = a_rt;
        in_reg_write_en  = a_rwe;
        in_reg_write_src = a_src;
        in_reg_write_dst = a_dst;
    endtask

    // Called just after the accept edge; ack is raised n cycles after req rose.
    task automatic run_mem(input int n, input logic [31:0] rdat, input logic [31:0] eaddr,
                           input logic [3:0] ebe, output int stall_cycles);
        stall_cycles = 0;
        for (int i = 0; i < n; i++) begin
            if (mem_stall) stall_cycles++;
            tick();
        end
        if (mem_stall) stall_cycles++;
        chk("busy_req", 32'(dmem_req), 32'd1);
        chk("busy_addr", dmem_addr, eaddr);
        chk("busy_be", 32'(dmem_be), 32'(ebe));
        dmem_ack   = 1'b1;
        dmem_rdata = rdat;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_mem_size = 2'd0;
        in_mem_sign = 1'b0; in_alu_result = '0; in_store_data = '0; in_pc = '0;
        in_rd = '0; in_rt = '0; in_reg_write_en = 1'b0; in_reg_write_src = '0;
        in_reg_write_dst = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_addr_error", 32'(addr_error), 32'd0);
        chk("rst_pc", pc, 32'd0);
        rst_n = 1'b1;
        tick();

        // Word load at 0x100, ack 3 cycles after req.
        drive(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'h40, 5'd3, 5'd4, 1, 2'd1, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("wl_we", 32'(dmem_we), 32'd0);
        chk("wl_wb_idle", 32'(wb_valid), 32'd0);
        run_mem(3, 32'hDEADBEEF, 32'h100, 4'b1111, sc);
        chk("wl_stall_cycles", 32'(sc), 32'd4);
        chk("wl_wb_valid", 32'(wb_valid), 32'd1);
        chk("wl_mem_data", mem_data, 32'hDEADBEEF);
        chk("wl_pc", pc, 32'h40);
        chk("wl_rd", 32'(rd), 32'd3);
        chk("wl_rwe", 32'(reg_write_en), 32'd1);
        chk("wl_req_drop", 32'(dmem_req), 32'd0);
        chk("wl_stall_drop", 32'(mem_stall), 32'd0);
        tick();
        chk("wl_pulse", 32'(wb_valid), 32'd0);
        chk("wl_hold", mem_data, 32'hDEADBEEF);

        // Signed byte load at 0x103, ack in the first req cycle.
        drive(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h44, 5'd5, 5'd6, 1, 2'd1, 2'd0);
        tick();
        in_valid = 1'b0;
        run_mem(0, 32'h80FF0102, 32'h100, 4'b1000, sc);
        chk("sb_stall_cycles", 32'(sc), 32'd1);
        chk("sb_mem_data", mem_data, 32'hFFFFFF80);

        // Same byte load, zero-extended.
        drive(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h48, 5'd5, 5'd6, 1, 2'd1, 2'd0);
        tick();
        in_valid = 1'b0;
        run_mem(2, 32'h80FF0102, 32'h100, 4'b1000, sc);
        chk("ub_mem_data", mem_data, 32'h00000080);

        // Half store at 0x202.
        drive(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'h4C, 5'd0, 5'd7, 0, 2'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("hs_we", 32'(dmem_we), 32'd1);
        chk("hs_wdata", dmem_wdata, 32'hABCDABCD);
        run_mem(1, 32'hFFFFFFFF, 32'h200, 4'b1100, sc);
        chk("hs_wb_valid", 32'(wb_valid), 32'd1);
        chk("hs_rwe", 32'(reg_write_en), 32'd0);
        chk("hs_mem_data", mem_data, 32'h0);
        chk("hs_alu", alu_result, 32'h202);

        // Signed half load from the upper half-word.
        drive(1, 0, 2'd1, 1, 32'h2, 32'h0, 32'h50, 5'd9, 5'd1, 1, 2'd1, 2'd1);
        tick();
        in_valid = 1'b0;
        run_mem(1, 32'h92340000, 32'h0, 4'b1100, sc);
        chk("sh_mem_data", mem_data, 32'hFFFF9234);

        // Misaligned word load at 0x102.
        drive(1, 0, 2'd2, 0, 32'h102, 32'h0, 32'h54, 5'd8, 5'd9, 1, 2'd2, 2'd1);
        tick();
        in_valid = 1'b0;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_addr_error", 32'(addr_error), 32'd1);
        chk("mis_rwe", 32'(reg_write_en), 32'd0);
        chk("mis_pc", pc, 32'h54);
        chk("mis_mem_data", mem_data, 32'h0);
        chk("mis_src", 32'(reg_write_src), 32'd2);
        tick();
        chk("mis_pulse", 32'(wb_valid), 32'd0);
        chk("mis_err_clear", 32'(addr_error), 32'd0);
        chk("mis_no_req", 32'(dmem_req), 32'd0);

        // Three back-to-back ALU ops.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 2'd2, 0, 32'h1000 + 32'(i), 32'h0, 32'(i * 4), 5'(i + 1), 5'd0, 1, 2'd0, 2'd0);
            tick();
            chk("alu_wb_valid", 32'(wb_valid), 32'd1);
            chk("alu_pc", pc, 32'(i * 4));
            chk("alu_result", alu_result, 32'h1000 + 32'(i));
            chk("alu_stall", 32'(mem_stall), 32'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("alu_pulse_end", 32'(wb_valid), 32'd0);

        // Bundle held upstream during BUSY is taken only after the ack.
        drive(1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h60, 5'd2, 5'd3, 1, 2'd1, 2'd0);
        tick();
        drive(0, 0, 2'd2, 0, 32'h777, 32'h0, 32'h64, 5'd4, 5'd5, 1, 2'd0, 2'd0);
        run_mem(1, 32'h11223344, 32'h300, 4'b1111, sc);
        chk("hold_load_pc", pc, 32'h60);
        chk("hold_load_data", mem_data, 32'h11223344);
        tick();
        in_valid = 1'b0;
        chk("hold_alu_valid", 32'(wb_valid), 32'd1);
        chk("hold_alu_pc", pc, 32'h64);
        chk("hold_alu_result", alu_result, 32'h777);
        chk("hold_alu_mem_data", mem_data, 32'h0);
        tick();
        chk("hold_pulse_end", 32'(wb_valid), 32'd0);

        // Reset while BUSY, then a late ack.
        drive(1, 0, 2'd2, 0, 32'h400, 32'h0, 32'h70, 5'd1, 5'd1, 1, 2'd1, 2'd0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_stall", 32'(mem_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_req", 32'(dmem_req), 32'd0);
        chk("rst_busy_stall", 32'(mem_stall), 32'd0);
        chk("rst_busy_wb", 32'(wb_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_wb", 32'(wb_valid), 32'd0);
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_stall", 32'(mem_stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
